clmul8_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit truncated carry-less multiplier among NUM_REQ requesters.
- The multiplier computes the low 8 bits of the GF(2) polynomial product a·b.
- Each requester issues operand pairs through a valid/ready handshake.
- The block grants one requester per cycle, computes the product, and returns it through a single-entry registered response port tagged with the requester ID.

---
 rtl/clmul8_arbiter.sv | 135 +++++++++++++
 tb/tb_clmul8_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clmul8_arbiter.sv
// Round-robin arbiter that shares one 8-bit truncated carry-less multiplier
// between NUM_REQ requesters. Results go to a single registered response slot.
module clmul8_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_y,
    output logic [ID_W-1:0]        rsp_id
);

    localparam int SUM_W = ID_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_y_q, rsp_y_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic [7:0]      a_arr [NUM_REQ];
    logic [7:0]      b_arr [NUM_REQ];
    logic [7:0]      sel_a, sel_b, product;

    logic            can_accept;
    logic            grant_found;
    logic            accept_en;
    logic [ID_W-1:0] grant_idx;
    logic [SUM_W-1:0] cand;
    logic [SUM_W-1:0] ptr_inc;

    function automatic logic [7:0] clmul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            if (b[j]) begin
                y = y ^ (a << j);
            end
        end
        return y;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[8*gi +: 8];
            assign b_arr[gi]     = req_b[8*gi +: 8];
            assign req_ready[gi] = accept_en & (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Draining and refilling in the same cycle keeps throughput at one result per clock.
    assign can_accept = (state_q == EMPTY) | (rsp_ready & rsp_valid_q);

    // First valid requester at or after the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_q} + SUM_W'(off);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign accept_en = can_accept & grant_found & ~rst;

    assign sel_a   = a_arr[grant_idx];
    assign sel_b   = b_arr[grant_idx];
    assign product = clmul8(sel_a, sel_b);

    always_comb begin
        ptr_inc = {1'b0, grant_idx} + SUM_W'(1);
        if (ptr_inc == SUM_W'(NUM_REQ)) begin
            ptr_inc = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (accept_en) begin
            state_d     = FULL;
            rsp_valid_d = 1'b1;
            rsp_y_d     = product;
            rsp_id_d    = grant_idx;
            ptr_d       = ptr_inc[ID_W-1:0];
        end else if (rsp_valid_q && rsp_ready) begin
            // Drained with nothing new: data and id keep their last value.
            state_d     = EMPTY;
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= 8'h00;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_clmul8_arbiter.sv
// Scoreboard bench for clmul8_arbiter: a reference arbiter pushes expected
// results on each grant, a monitor pops and compares on each response handshake.
module tb_clmul8_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_y;
    logic [ID_W-1:0]      rsp_id;

    clmul8_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      y;
    } exp_t;

    exp_t sb[$];
    int   id_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_xfer   = 0;
    int   m_ptr    = 0;
    bit   m_full   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bit-by-bit polynomial product, low byte only.
    function automatic logic [7:0] ref_clmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        for (int k = 0; k < 8; k++) begin
            y[k] = 1'b0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if (i + j == k) y[k] = y[k] ^ (a[i] & b[j]);
        end
        return y;
    endfunction

    // Reference arbiter: predicts req_ready and rsp_valid, queues expected results.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [7:0]         ea, eb;
        exp_t               e;
        bit                 found;
        int                 idx;
        exp_ready = '0;
        found     = 1'b0;
        idx       = 0;
        if (!rst && (!m_full || rsp_ready)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    idx   = c;
                end
            end
        end
        if (found) exp_ready[idx] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (rst) begin
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (found) begin
            ea   = req_a[8*idx +: 8];
            eb   = req_b[8*idx +: 8];
            e.id = ID_W'(idx);
            e.y  = ref_clmul(ea, eb);
            sb.push_back(e);
            m_full = 1'b1;
            m_ptr  = (idx + 1) % NUM_REQ;
            n_xfer++;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
    end

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: got response id=%0d y=0x%02h, expected none", rsp_id, rsp_y);
            end else begin
                e = sb.pop_front();
                chk("rsp_y", 32'(rsp_y), 32'(e.y));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                id_log.push_back(int'(rsp_id));
                $display("rsp id=%0d y=0x%02h exp_y=0x%02h", rsp_id, rsp_y, e.y);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    logic [7:0] corner_a [5] = '{8'h03, 8'hFF, 8'h80, 8'h0F, 8'h00};
    logic [7:0] corner_b [5] = '{8'h03, 8'hFF, 8'h02, 8'h11, 8'hA7};
    logic [7:0] corner_y [5] = '{8'h05, 8'h55, 8'h00, 8'hFF, 8'h00};
    int         rr_exp   [11] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0};

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int target;
        int cnt;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) cyc();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_y", 32'(rsp_y), 32'h00);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        cyc();

        // Single request from requester 0, then arithmetic corners.
        rsp_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            req_valid = 4'b0001;
            set_op(0, corner_a[v], corner_b[v]);
            #1;
            chk("single_grant", 32'(req_ready), 32'b0001);
            cyc();
            req_valid = '0;
            chk("corner_valid", 32'(rsp_valid), 32'd1);
            chk("corner_y", 32'(rsp_y), 32'(corner_y[v]));
            chk("corner_id", 32'(rsp_id), 32'd0);
            cyc();
            chk("corner_drained", 32'(rsp_valid), 32'd0);
        end

        // Random traffic with random backpressure.
        target = n_xfer + 10000;
        cnt    = 0;
        while (n_xfer < target && cnt < 40000) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            req_a     = $urandom();
            req_b     = $urandom();
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
            cnt++;
        end
        chk("random_done", 32'(n_xfer >= target), 32'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) cyc();

        // Round-robin: all valid, then requester 2 drops out.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        id_log.delete();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i + 1), 8'h03);
        req_valid = 4'b1111;
        repeat (6) cyc();
        req_valid = 4'b1011;
        repeat (5) cyc();
        req_valid = '0;
        repeat (2) cyc();
        chk("rr_count", 32'(id_log.size()), 32'd11);
        for (int k = 0; k < 11 && k < id_log.size(); k++)
            chk("rr_seq", 32'(id_log[k]), 32'(rr_exp[k]));

        // Backpressure: hold requester 0's result while 1 and 3 wait.
        rsp_ready = 1'b0;
        set_op(0, 8'h0F, 8'h11);
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_y", 32'(rsp_y), 32'hFF);
            chk("bp_id", 32'(rsp_id), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = 4'b1000;
        chk("bp_next_id1", 32'(rsp_id), 32'd1);
        cyc();
        req_valid = '0;
        chk("bp_next_id3", 32'(rsp_id), 32'd3);
        chk("bp_next_valid", 32'(rsp_valid), 32'd1);
        cyc();
        chk("bp_drained", 32'(rsp_valid), 32'd0);

        // Reset while a result is held; pointer would otherwise favour requester 2.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        chk("mid_held", 32'(rsp_valid), 32'd1);
        cyc();
        rst       = 1'b1;
        req_valid = 4'b0101;
        #1;
        chk("rst_ready_forced", 32'(req_ready), 32'd0);
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_y", 32'(rsp_y), 32'h00);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        #1;
        chk("mid_rst_grant", 32'(req_ready), 32'b0001);
        rsp_ready = 1'b1;
        cyc();
        req_valid = 4'b0100;
        chk("after_rst_id0", 32'(rsp_id), 32'd0);
        cyc();
        req_valid = '0;
        chk("after_rst_id2", 32'(rsp_id), 32'd2);
        repeat (2) cyc();

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
